// File: rtl/regfile_access_pkg.sv
// Shared types and helpers for the register block request sequencer.
// Holds the FSM state encoding, default sizing and the strobe decoder.
package regfile_access_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_EN,
    RD_WAIT,
    RSP
  } state_t;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_NUM_WORDS  = 2;
  localparam int DEF_TURNAROUND = 1;
  localparam int MAX_WORDS      = 32;

  // Out-of-range addresses decode to an all-zero strobe.
  function automatic logic [MAX_WORDS-1:0] onehot_decode(
    input logic [31:0] addr,
    input int          num_words
  );
    logic [MAX_WORDS-1:0] oh;
    oh = '0;
    if (addr < 32'(num_words) && addr < 32'(MAX_WORDS))
      oh[addr[4:0]] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/regfile_access_spacing_chk.sv
// Bind-able checker for the strobes driven into the register block.
// Flags overlapping strobes and reads that follow a write too closely.
module regfile_access_spacing_chk #(
  parameter int NUM_WORDS  = 2,
  parameter int TURNAROUND = 1
) (
  input logic                 clk,
  input logic                 rst,
  input logic [NUM_WORDS-1:0] write_enable,
  input logic [NUM_WORDS-1:0] read_enable
);

  // Cycles elapsed since the last write strobe, minus one, saturating.
  logic [2:0] gap;

  always_ff @(posedge clk) begin
    if (rst)
      gap <= 3'd7;
    else if (|write_enable)
      gap <= '0;
    else if (gap != 3'd7)
      gap <= gap + 3'd1;

    if (!rst) begin
      assert (!(|write_enable && |read_enable));
      assert ($onehot0(write_enable));
      assert ($onehot0(read_enable));
      if (|read_enable)
        assert (gap >= 3'(TURNAROUND));
    end
  end

endmodule

// File: rtl/regfile_access_sequencer.sv
// Request sequencer feeding strobes to the two-word register block.
// Enforces write-to-read turnaround with a reloadable lock counter.
module regfile_access_sequencer
  import regfile_access_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_WORDS  = DEF_NUM_WORDS,
  parameter int TURNAROUND = DEF_TURNAROUND,
  parameter int ADDR_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic [NUM_WORDS-1:0] write_enable,
  output logic [NUM_WORDS-1:0] read_enable,
  output logic [DATA_W-1:0]    write_data,
  input  logic [DATA_W-1:0]    read_data
);

  state_t               state;
  logic [2:0]           lock_cnt;
  logic                 rd_err;
  logic                 accept;
  logic                 in_range;
  logic [NUM_WORDS-1:0] dec;

  assign req_ready = (state == IDLE) &&
                     (lock_cnt == 3'd0 || req_write);
  assign accept    = req_valid && req_ready;
  assign in_range  = 32'(req_addr) < 32'(NUM_WORDS);
  assign dec       = NUM_WORDS'(onehot_decode(32'(req_addr), NUM_WORDS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lock_cnt     <= '0;
      rd_err       <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      write_enable <= '0;
      read_enable  <= '0;
      write_data   <= '0;
    end else begin
      write_enable <= '0;
      read_enable  <= '0;
      if (lock_cnt != 3'd0)
        lock_cnt <= lock_cnt - 3'd1;

      unique case (state)
        IDLE: begin
          if (accept) begin
            if (req_write) begin
              // Dropped writes must not stall later reads.
              if (in_range) begin
                write_enable <= dec;
                write_data   <= req_wdata;
                lock_cnt     <= 3'(TURNAROUND);
              end
            end else begin
              read_enable <= dec;
              rd_err      <= !in_range;
              state       <= RD_EN;
            end
          end
        end
        RD_EN: state <= RD_WAIT;
        RD_WAIT: begin
          rsp_rdata <= rd_err ? '0 : read_data;
          rsp_err   <= rd_err;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Directed bench for the register block request sequencer.
// Drives default and three-word instances against a small register model.
module tb_regfile_access_sequencer;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid, req_ready, req_write;
  logic [0:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;
  logic [1:0]  write_enable, read_enable;
  logic [15:0] write_data, read_data;

  logic        req_valid3, req_ready3, req_write3;
  logic [1:0]  req_addr3;
  logic [15:0] req_wdata3;
  logic        rsp_valid3, rsp_ready3, rsp_err3;
  logic [15:0] rsp_rdata3;
  logic [2:0]  write_enable3, read_enable3;
  logic [15:0] write_data3;
  logic [15:0] read_data3;

  logic [15:0] mem0, mem1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_access_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .write_enable(write_enable), .read_enable(read_enable),
    .write_data(write_data), .read_data(read_data)
  );

  regfile_access_sequencer #(.NUM_WORDS(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_write(req_write3), .req_addr(req_addr3),
    .req_wdata(req_wdata3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .write_enable(write_enable3), .read_enable(read_enable3),
    .write_data(write_data3), .read_data(read_data3)
  );

  regfile_access_spacing_chk chk_i (
    .clk(clk), .rst(rst),
    .write_enable(write_enable), .read_enable(read_enable)
  );

  // Two-word register block: data valid the cycle after read_enable.
  always_ff @(posedge clk) begin
    if (write_enable[0]) mem0 <= write_data;
    if (write_enable[1]) mem1 <= write_data;
    if (|read_enable)
      read_data <= read_enable[1] ? mem1 : mem0;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    rsp_ready = 0;
    req_valid3 = 0; req_write3 = 0; req_addr3 = '0;
    req_wdata3 = '0; rsp_ready3 = 1; read_data3 = 16'hFFFF;
    mem0 = '0; mem1 = '0; read_data = '0;
    tick; tick;
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_rspv", 32'(rsp_valid), 32'h0);
    chk("rst_we", 32'(write_enable), 32'h0);
    chk("rst_re", 32'(read_enable), 32'h0);
    chk("rst_wd", 32'(write_data), 32'h0);
    chk("rst_rd", 32'(rsp_rdata), 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);

    // Single write to addr 1.
    req_valid = 1; req_write = 1; req_addr = 1; req_wdata = 16'hA5A5;
    #1 chk("w1_ready", 32'(req_ready), 32'h1);
    tick;
    req_valid = 0;
    #1;
    chk("w1_we", 32'(write_enable), 32'h2);
    chk("w1_wd", 32'(write_data), 32'hA5A5);
    chk("w1_re", 32'(read_enable), 32'h0);
    tick;
    chk("w1_we_off", 32'(write_enable), 32'h0);
    chk("w1_wd_hold", 32'(write_data), 32'hA5A5);
    tick; tick;

    // Write then read with turnaround lock.
    rsp_ready = 1;
    req_valid = 1; req_write = 1; req_addr = 0; req_wdata = 16'h1111;
    tick;
    req_write = 0;
    #1;
    chk("ta_lock", 32'(req_ready), 32'h0);
    chk("ta_we", 32'(write_enable), 32'h1);
    tick;
    #1 chk("ta_open", 32'(req_ready), 32'h1);
    tick;
    req_valid = 0;
    #1;
    chk("ta_re", 32'(read_enable), 32'h1);
    chk("ta_we0", 32'(write_enable), 32'h0);
    tick;
    chk("ta_rspv0", 32'(rsp_valid), 32'h0);
    tick;
    chk("ta_rspv", 32'(rsp_valid), 32'h1);
    chk("ta_rd", 32'(rsp_rdata), 32'h1111);
    tick;
    chk("ta_done", 32'(rsp_valid), 32'h0);
    chk("ta_idle", 32'(req_ready), 32'h1);

    // Read held with rsp_ready low.
    rsp_ready = 0;
    req_valid = 1; req_write = 1; req_addr = 1; req_wdata = 16'h1234;
    tick;
    req_valid = 0;
    tick;
    req_valid = 1; req_write = 0; req_addr = 1;
    #1 chk("rd_ready", 32'(req_ready), 32'h1);
    tick;
    req_valid = 0;
    #1 chk("rd_re", 32'(read_enable), 32'h2);
    tick;
    chk("rd_wait", 32'(rsp_valid), 32'h0);
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("rd_hold_v", 32'(rsp_valid), 32'h1);
      chk("rd_hold_d", 32'(rsp_rdata), 32'h1234);
      chk("rd_busy", 32'(req_ready), 32'h0);
      tick;
    end
    rsp_ready = 1;
    #1 chk("rd_last", 32'(rsp_valid), 32'h1);
    tick;
    chk("rd_clear", 32'(rsp_valid), 32'h0);

    // Back-to-back writes.
    req_valid = 1; req_write = 1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 1'(i);
      req_wdata = 16'h0100 + 16'(i);
      #1 chk("b2b_ready", 32'(req_ready), 32'h1);
      if (i > 0)
        chk("b2b_we", 32'(write_enable), (i % 2 == 1) ? 32'h1 : 32'h2);
      tick;
    end
    req_valid = 0;
    #1;
    chk("b2b_we_last", 32'(write_enable), 32'h2);
    chk("b2b_wd_last", 32'(write_data), 32'h0103);
    tick; tick;

    // Three-word instance: out-of-range write then read.
    req_valid3 = 1; req_write3 = 1; req_addr3 = 3; req_wdata3 = 16'hBEEF;
    tick;
    req_write3 = 0;
    #1;
    chk("oor_we", 32'(write_enable3), 32'h0);
    chk("oor_nolock", 32'(req_ready3), 32'h1);
    tick;
    req_valid3 = 0;
    #1 chk("oor_re", 32'(read_enable3), 32'h0);
    tick;
    chk("oor_re2", 32'(read_enable3), 32'h0);
    tick;
    chk("oor_v", 32'(rsp_valid3), 32'h1);
    chk("oor_err", 32'(rsp_err3), 32'h1);
    chk("oor_rd", 32'(rsp_rdata3), 32'h0);
    tick;

    // Reset in the middle of a read.
    req_valid = 1; req_write = 0; req_addr = 0;
    tick;
    req_valid = 0;
    tick;
    rst = 1;
    tick;
    rst = 0;
    #1;
    chk("mr_ready", 32'(req_ready), 32'h1);
    chk("mr_rspv", 32'(rsp_valid), 32'h0);
    chk("mr_re", 32'(read_enable), 32'h0);
    chk("mr_we", 32'(write_enable), 32'h0);
    chk("mr_wd", 32'(write_data), 32'h0);
    chk("mr_rd", 32'(rsp_rdata), 32'h0);
    chk("mr_err", 32'(rsp_err), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("mr_norsp", 32'(rsp_valid), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_access_sequencer.md
# regfile_access_sequencer

Upstream request sequencer for the two-word register block. Converts a valid/ready request stream (read or write, word address, data) into the one-hot `write_enable`/`read_enable` strobes and `write_data` that the register block consumes. It captures the register block's `read_data` into a held response. By construction it guarantees the register block's rule that a read strobe never occurs in the cycle directly after a write strobe.

## Interface
- `DATA_W`, default 16: data width, matching the register block.
- `NUM_WORDS`, default 2: number of words; also the width of the one-hot enable buses.
- `TURNAROUND`, default 1 (legal 1..7): minimum idle cycles between a `write_enable` cycle and a later `read_enable` cycle.
- `ADDR_W`, default `$clog2(NUM_WORDS)` (minimum 1): request address width.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  `ADDR_W`  word index.
- `req_wdata`  in  `DATA_W`  write data.
- `rsp_valid`  out  1  read response held until `rsp_ready`.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  `DATA_W`  captured read data.
- `rsp_err`  out  1  read address out of range.
- `write_enable`  out  `NUM_WORDS`  one-hot write strobe to the register block.
- `read_enable`  out  `NUM_WORDS`  one-hot read strobe to the register block.
- `write_data`  out  `DATA_W`  write data to the register block.
- `read_data`  in  `DATA_W`  from the register block; valid the cycle after `read_enable`.

## Operation
- States:
  - IDLE: accepts requests.
  - RD_EN: `read_enable` driven.
  - RD_WAIT: `read_data` sampled at the end of this cycle.
  - RSP: response held.
- `req_ready` = (state == IDLE) && (`lock_cnt` == 0 || `req_write`).
  - Writes may go back-to-back.
  - Reads are blocked while the turnaround lock is active.
- Write accept in IDLE:
  - Next cycle: `write_enable` = one-hot(`req_addr`) for exactly one cycle; `write_data` = `req_wdata`.
  - `lock_cnt` is loaded with `TURNAROUND`.
  - State stays IDLE.
- `lock_cnt` decrements by 1 each cycle while nonzero. It reloads on every write accept; reload wins over decrement.
- Read accept in IDLE: IDLE → RD_EN → RD_WAIT → RSP.
  - `read_enable` = one-hot(`req_addr`) during RD_EN only.
  - End of RD_WAIT: `rsp_rdata` ← `read_data`.
- RSP: `rsp_valid` = 1, with `rsp_rdata`/`rsp_err` stable. On `rsp_valid && rsp_ready`, go to IDLE.
- Out-of-range address (`req_addr` >= `NUM_WORDS`):
  - Write: accepted and dropped; `write_enable` stays 0 and `lock_cnt` is not loaded.
  - Read: accepted; `read_enable` stays 0; response carries `rsp_rdata` = 0 and `rsp_err` = 1 with the normal latency.
- `write_enable` and `read_enable` are never nonzero in the same cycle. At most one bit of each is set.
- `write_data` holds its last value when not strobing.

## Timing
- Reset values (synchronous `rst`):
  - State IDLE, `lock_cnt` 0.
  - `req_ready` 1 (follows the IDLE formula).
  - `rsp_valid`, `rsp_err`, `write_enable`, `read_enable` all 0.
  - `rsp_rdata` and `write_data` 0.
- Reset mid-read or during RSP discards the transaction; no response is produced.
- Write latency: accept at cycle T → `write_enable` in T+1.
- Read latency: accept at T → `read_enable` in T+1, `read_data` sampled at end of T+2, `rsp_valid` from T+3.
- Turnaround: write accept at T → the earliest read accept is T+1+`TURNAROUND`. This puts `read_enable` ≥ `TURNAROUND`+1 cycles after the `write_enable` cycle.
- `req_ready` is combinational from state, `lock_cnt` and `req_write`. All other outputs are registered.
- Throughput: 1 write/cycle. 1 read per 4 cycles when `rsp_ready` is tied high.

## Structure
- Package `regfile_access_pkg` holds:
  - the state enum (IDLE, RD_EN, RD_WAIT, RSP);
  - the default `DATA_W`/`NUM_WORDS`/`TURNAROUND` constants;
  - an `onehot_decode` function returning 0 for out-of-range addresses.
- No sub-module: a single FSM plus lock counter.
- A bind-able assertion module re-checks write-then-read spacing at the enable outputs.

## Test plan
- Write 16'hA5A5 to addr 1 → `write_enable` = 2'b10 for one cycle at T+1, `write_data` = 16'hA5A5, `read_enable` 0.
- Write addr 0 at T, read addr 0 presented from T+1 with `TURNAROUND` = 1 → `req_ready` low at T+1, read accepted T+2, `read_enable` = 2'b01 at T+3.
- Read addr 1, model returns 16'h1234 → `rsp_valid` at T+3, `rsp_rdata` = 16'h1234; holds 5 cycles with `rsp_ready` low, then clears the cycle after `rsp_ready`.
- Four back-to-back writes (addr 0,1,0,1) → `req_ready` stays 1 and `write_enable` = 01,10,01,10 on consecutive cycles.
- `NUM_WORDS` = 3, read addr 3 → no `read_enable`, `rsp_err` = 1, `rsp_rdata` = 0 at T+3.
- Assert `rst` during RD_WAIT → next cycle all outputs at reset values, `req_ready` = 1, no `rsp_valid` afterwards.
